// File: rtl/ahb_sram_wbuf.sv
// AHB-lite zero-wait SRAM row array with a one-entry posted write buffer.
// Optional SRAM_ADDR_CHK_EN: window/size/alignment checks with ERROR response.
module ahb_sram_wbuf #(
  parameter int unsigned DWIDTH    = 128,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [31:0]       haddr,
  input  logic [3:0]        hsize,
  input  logic              hwrite,
  input  logic [DWIDTH-1:0] hwdata,
  output logic [DWIDTH-1:0] hrdata,
  output logic              hready,
  output logic              hresp
);

  localparam int unsigned NB = DWIDTH / 8;
  localparam int unsigned BW = $clog2(NB);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = BW + AW;

  typedef enum logic [1:0] {
    SZ_B, SZ_H, SZ_W, SZ_R
  } sz_e;

  function automatic logic [DWIDTH-1:0] bexp(
    input logic [NB-1:0] m
  );
    logic [DWIDTH-1:0] r;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  logic [DWIDTH-1:0] mem_q [DEPTH];

  sz_e           sz;
  logic          rsvd;
  logic          mis;
  logic [BW-1:0] off;
  logic [NB-1:0] amask;
  logic [AW-1:0] row;

  always_comb begin
    sz   = SZ_W;
    rsvd = 1'b0;
    unique case (hsize)
      4'b0000: sz = SZ_B;
      4'b0001: sz = SZ_H;
      4'b0010: sz = SZ_W;
      4'b1000: sz = SZ_R;
      default: rsvd = 1'b1;
    endcase
  end

  // Offset is truncated to the natural alignment of the size.
  always_comb begin
    off   = haddr[BW-1:0];
    mis   = 1'b0;
    amask = '1;
    unique case (sz)
      SZ_B: begin
        amask = NB'(1);
      end
      SZ_H: begin
        mis    = off[0];
        off[0] = 1'b0;
        amask  = NB'(3);
      end
      SZ_W: begin
        mis      = |off[1:0];
        off[1:0] = 2'b00;
        amask    = NB'(15);
      end
      default: begin
        mis = |off;
        off = '0;
      end
    endcase
    amask = amask << off;
  end

  assign row = haddr[TW-1:BW];

  logic acc;
  logic err;
  logic rd_acc;
  logic wr_acc;
  logic unused_bits;

  assign acc = hready & hsel & htrans[1];

`ifdef SRAM_ADDR_CHK_EN
  assign err = acc & ((haddr[31:TW] != BASE_ADDR[31:TW])
                      | rsvd | mis);
  assign unused_bits = htrans[0];
`else
  assign err = 1'b0;
  assign unused_bits = ^{htrans[0], rsvd, mis,
                         haddr[31:TW], BASE_ADDR};
`endif

  assign rd_acc = acc & ~err & ~hwrite;
  assign wr_acc = acc & ~err & hwrite;

  logic              wr_dp_q;
  logic [AW-1:0]     wr_row_q;
  logic [NB-1:0]     wr_mask_q;
  sz_e               wr_sz_q;
  logic              buf_vld_q;
  logic              buf_vld_d;
  logic [AW-1:0]     buf_row_q;
  logic [NB-1:0]     buf_mask_q;
  logic [DWIDTH-1:0] buf_data_q;
  logic [DWIDTH-1:0] sram_q;
  logic [DWIDTH-1:0] fwd_data_q;
  logic [NB-1:0]     fwd_mask_q;
  sz_e               rd_sz_q;
  logic [BW-1:0]     rd_off_q;

  logic [DWIDTH-1:0] wdata;

  always_comb begin
    unique case (wr_sz_q)
      SZ_B:    wdata = {NB{hwdata[7:0]}};
      SZ_H:    wdata = {(NB/2){hwdata[15:0]}};
      SZ_W:    wdata = {(NB/4){hwdata[31:0]}};
      default: wdata = hwdata;
    endcase
  end

  logic buf_hit;
  logic wdp_hit;

  assign buf_hit = buf_vld_q & (buf_row_q == row);
  assign wdp_hit = wr_dp_q & (wr_row_q == row);

  // A read owns the single port; writes park in the buffer.
  assign buf_vld_d = rd_acc ? (buf_vld_q | wr_dp_q)
                            : 1'b0;

  logic              mem_we;
  logic [AW-1:0]     mem_row;
  logic [NB-1:0]     mem_mask;
  logic [DWIDTH-1:0] mem_data;

  assign mem_we   = ~rd_acc & (wr_dp_q | buf_vld_q);
  assign mem_row  = wr_dp_q ? wr_row_q  : buf_row_q;
  assign mem_mask = wr_dp_q ? wr_mask_q : buf_mask_q;
  assign mem_data = wr_dp_q ? wdata     : buf_data_q;

  always_ff @(posedge hclk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++)
        if (mem_mask[i])
          mem_q[mem_row][8*i +: 8] <= mem_data[8*i +: 8];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_dp_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_mask_q  <= '0;
      wr_sz_q    <= SZ_B;
      buf_vld_q  <= 1'b0;
      buf_row_q  <= '0;
      buf_mask_q <= '0;
      buf_data_q <= '0;
      sram_q     <= '0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      rd_sz_q    <= SZ_B;
      rd_off_q   <= '0;
    end else begin
      wr_dp_q   <= wr_acc;
      buf_vld_q <= buf_vld_d;
      if (wr_acc) begin
        wr_row_q  <= row;
        wr_mask_q <= amask;
        wr_sz_q   <= sz;
      end
      if (rd_acc & wr_dp_q) begin
        buf_row_q  <= wr_row_q;
        buf_mask_q <= wr_mask_q;
        buf_data_q <= wdata;
      end
      if (rd_acc) begin
        sram_q     <= mem_q[row];
        rd_sz_q    <= sz;
        rd_off_q   <= off;
        fwd_mask_q <= buf_hit ? buf_mask_q
                    : wdp_hit ? wr_mask_q : '0;
        fwd_data_q <= buf_hit ? buf_data_q : wdata;
      end
    end
  end

  logic [DWIDTH-1:0] merged;
  logic [DWIDTH-1:0] shifted;

  assign merged  = (sram_q & ~bexp(fwd_mask_q))
                 | (fwd_data_q & bexp(fwd_mask_q));
  assign shifted = merged >> {rd_off_q, 3'b000};

  always_comb begin
    unique case (rd_sz_q)
      SZ_B:    hrdata = DWIDTH'(shifted[7:0]);
      SZ_H:    hrdata = DWIDTH'(shifted[15:0]);
      SZ_W:    hrdata = DWIDTH'(shifted[31:0]);
      default: hrdata = merged;
    endcase
  end

`ifdef SRAM_ADDR_CHK_EN
  typedef enum logic [1:0] {
    ST_OK, ST_ERR1, ST_ERR2
  } st_e;

  st_e  st_q;
  logic hready_q;
  logic hresp_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      st_q     <= ST_OK;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      unique case (st_q)
        ST_ERR1: begin
          st_q     <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          if (err) begin
            st_q     <= ST_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= 1'b1;
          end else begin
            st_q     <= ST_OK;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign hready = hready_q;
  assign hresp  = hresp_q;
`else
  assign hready = 1'b1;
  assign hresp  = 1'b0;
`endif

  // The write address cycle before any write data phase drained the buffer.
  always @(posedge hclk)
    if (hresetn)
      a_single: assert (!(wr_dp_q && buf_vld_q));

endmodule

// File: tb/tb_ahb_sram_wbuf.sv
// Directed bench for ahb_sram_wbuf: byte-level memory model checked every
// cycle, plus literal expectations for the listed scenarios.
`timescale 1ns/1ps
module tb_ahb_sram_wbuf;

  localparam int DW    = 128;
  localparam int DEPTH = 4096;
  localparam int NB    = DW / 8;
  localparam int WIN   = DEPTH * NB;
  localparam logic [31:0] BASE = 32'h2000_0000;

  localparam logic [3:0] S_B = 4'b0000;
  localparam logic [3:0] S_H = 4'b0001;
  localparam logic [3:0] S_W = 4'b0010;
  localparam logic [3:0] S_R = 4'b1000;

  logic          hclk    = 1'b0;
  logic          hresetn = 1'b0;
  logic          hsel    = 1'b0;
  logic [1:0]    htrans  = 2'b00;
  logic [31:0]   haddr   = '0;
  logic [3:0]    hsize   = '0;
  logic          hwrite  = 1'b0;
  logic [DW-1:0] hwdata  = '0;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic          hresp;

  ahb_sram_wbuf #(
    .DWIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel),
    .htrans(htrans), .haddr(haddr), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Model: memory as a flat byte array of the address window.
  logic [7:0] mdl [WIN];

  function automatic int nbytes(input logic [3:0] s);
    case (s)
      S_B:     return 1;
      S_H:     return 2;
      S_R:     return NB;
      default: return 4;
    endcase
  endfunction

  function automatic int first(input logic [31:0] a, input int n);
    int w = int'(a % 32'(WIN));
    int o = w % NB;
    return w - o + (o - o % n);
  endfunction

  function automatic logic [DW-1:0] mread(input logic [31:0] a,
                                          input logic [3:0] s);
    logic [DW-1:0] r = '0;
    int n = nbytes(s);
    int b = first(a, n);
    for (int i = 0; i < n; i++) r[8*i +: 8] = mdl[b + i];
    return r;
  endfunction

  function automatic void mwrite(input logic [31:0] a,
                                 input logic [3:0] s,
                                 input logic [DW-1:0] d);
    int n = nbytes(s);
    int b = first(a, n);
    for (int i = 0; i < n; i++) mdl[b + i] = d[8*i +: 8];
  endfunction

  logic          pend_wr = 1'b0;
  logic [31:0]   pw_a    = '0;
  logic [3:0]    pw_s    = '0;
  logic [DW-1:0] exp_rd  = '0;

  always @(posedge hclk) begin
    if (!hresetn) begin
      pend_wr = 1'b0;
      exp_rd  = '0;
    end else begin
      if (pend_wr) mwrite(pw_a, pw_s, hwdata);
      if (hsel && htrans[1] && !hwrite) exp_rd = mread(haddr, hsize);
      pend_wr = hsel && htrans[1] && hwrite;
      pw_a    = haddr;
      pw_s    = hsize;
    end
  end

  always @(negedge hclk) begin
    if (hresetn) begin
      check("hready", DW'(hready), DW'(1));
      check("hresp", DW'(hresp), '0);
      check("hrdata", hrdata, exp_rd);
    end
  end

  logic [DW-1:0] nxt_wd = '0;

  task automatic cyc(input logic [1:0] t, input bit w,
                     input logic [31:0] a, input logic [3:0] s,
                     input logic [DW-1:0] wd);
    hsel   = (t != 2'b00);
    htrans = t;
    hwrite = w;
    haddr  = a;
    hsize  = s;
    hwdata = nxt_wd;
    nxt_wd = (w && t[1]) ? wd
           : {$urandom, $urandom, $urandom, $urandom};
    @(posedge hclk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s,
                    input logic [DW-1:0] d);
    cyc(2'b10, 1'b1, a, s, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] s);
    cyc(2'b10, 1'b0, a, s, '0);
  endtask

  task automatic idle();
    cyc(2'b00, 1'b0, 32'h0, 4'h0, '0);
  endtask

  function automatic logic [DW-1:0] init_row(input int r);
    return {4{32'hC0DE_0000 | 32'(r)}};
  endfunction

  localparam logic [DW-1:0] ROW5 = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [DW-1:0] R5W  = 128'h0123456789ABCDEF_DEADBEEF_89ABCDEF;
  localparam logic [DW-1:0] A6   = 128'hAAAA5555_12345678_9ABCDEF0_0F0FF0F0;
  localparam logic [DW-1:0] A6M  = 128'hAAAA5555_12345678_9ABCDEF0_55AAF0F0;
  localparam logic [DW-1:0] C3   = 128'h3333CCCC_3333CCCC_3333CCCC_3333CCCC;

  logic [7:0] sav [NB];

  initial begin
    repeat (3) @(posedge hclk);
    #1;
    check("rst_hready", DW'(hready), DW'(1));
    check("rst_hresp", DW'(hresp), '0);
    check("rst_hrdata", hrdata, '0);
    hresetn = 1'b1;

    for (int r = 0; r < 8; r++)
      wr(BASE + 32'(r * NB), S_R, init_row(r));
    idle();

    wr(BASE + 32'h50, S_R, ROW5);
    idle();
    rd(BASE + 32'h50, S_R);
    check("t1_row5", hrdata, ROW5);
    idle();

    wr(BASE + 32'h54, S_W, {96'hF00DF00DF00DF00DF00DF00D, 32'hDEADBEEF});
    rd(BASE + 32'h50, S_R);
    check("t2_fwd_word", hrdata, R5W);
    idle();

    wr(BASE + 32'h60, S_R, A6);
    for (int k = 0; k < 3; k++) begin
      rd(BASE + 32'h60, S_R);
      check("t3_buf_read", hrdata, A6);
    end
    rd(BASE + 32'h70, S_R);
    check("t3_other_row", hrdata, init_row(7));
    idle();
    idle();
    rd(BASE + 32'h60, S_R);
    check("t3_committed", hrdata, A6);

    wr(BASE + 32'h0, S_B, 128'hFFFFFF11);
    wr(BASE + 32'h1, S_B, 128'hFFFFFF22);
    rd(BASE + 32'h0, S_H);
    check("t4_hword", hrdata, 128'h2211);
    idle();

    rd(BASE + 32'h55, S_B);
    check("t5_byte", hrdata, 128'hBE);
    rd(BASE + 32'h58, S_W);
    check("t5_word", hrdata, 128'h89ABCDEF);
    rd(BASE + 32'h56, S_W);
    check("t5_misal_word", hrdata, 128'hDEADBEEF);
    rd(BASE + 32'h53, S_H);
    check("t5_misal_hword", hrdata, 128'h89AB);
    rd(BASE + 32'h54, 4'b0011);
    check("t5_rsvd_size", hrdata, 128'hDEADBEEF);
    rd(32'h3000_0050, S_R);
    check("t5_wrap", hrdata, R5W);
    cyc(2'b01, 1'b1, BASE + 32'h50, S_R, '1);
    idle();
    rd(BASE + 32'h50, S_R);
    check("t5_busy_nowrite", hrdata, R5W);

    wr(BASE + 32'h62, S_H, 128'h0000AAAA);
    wr(BASE + 32'h63, S_B, 128'h00000055);
    rd(BASE + 32'h60, S_R);
    check("t6_merge", hrdata, A6M);
    rd(BASE + 32'h70, S_R);
    check("t6_no_fwd", hrdata, init_row(7));
    idle();

    for (int i = 0; i < NB; i++) sav[i] = mdl[48 + i];
    wr(BASE + 32'h30, S_R, C3);
    rd(BASE + 32'h30, S_R);
    check("t7_fwd", hrdata, C3);
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    #1;
    hresetn = 1'b0;
    #1;
    check("t7_rst_hrdata", hrdata, '0);
    check("t7_rst_hready", DW'(hready), DW'(1));
    for (int i = 0; i < NB; i++) mdl[48 + i] = sav[i];
    @(posedge hclk);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    idle();
    idle();
    rd(BASE + 32'h30, S_R);
    check("t7_no_commit", hrdata, init_row(3));
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_sram_wbuf.md
Name: ahb_sram_wbuf

Overview:
- Zero-wait-state AHB-lite slave in front of a parametrised, byte-maskable single-port SRAM row array.
- Next-generation polynomial-memory wrapper for the mdmc datapath; generic in row width and depth.
- A one-entry posted write buffer with read forwarding removes the wait state a write-then-read sequence previously cost.
- Sits between the AHB interconnect and the coefficient storage used by the NTT/multiplier engines.

Parameters:
- DWIDTH, 128: row width in bits; multiple of 32, minimum 32.
- DEPTH, 4096: number of rows; power of 2.
- BASE_ADDR, 32'h2000_0000: window base; aligned to DEPTH*DWIDTH/8.

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- htrans  in  2  AHB transfer type; htrans[1]=1 means valid (NONSEQ/SEQ)
- haddr  in  32  byte address
- hsize  in  4  0000 byte, 0001 hword, 0010 word, 1000 full row, others reserved
- hwrite  in  1  1=write
- hwdata  in  DWIDTH  write data; narrow writes use the LSBs of hwdata[31:0]
- hrdata  out  DWIDTH  read data
- hready  out  1  transfer done
- hresp  out  1  error response

Behaviour:
- Reset: reset is hresetn, asynchronous, active-low; clock is hclk. hready=1, hresp=0, hrdata=0, buffer invalid, all latches 0. Array contents are not reset.
- Address phase: accepted when hready & hsel & htrans[1].
  - BW = log2(DWIDTH/8).
  - row = haddr[BW+log2(DEPTH)-1:BW].
  - lane offset = haddr[BW-1:0].
- Reads:
  - The SRAM is read at the address-phase clock edge; data appears in the next cycle (data phase), giving zero wait states.
  - Full row returns all DWIDTH bits.
  - Narrow reads return the selected bytes zero-extended in hrdata LSBs.
  - hrdata holds its last value when no read is in data phase.
- Writes:
  - Byte mask is derived from size and offset; narrow data is replicated from hwdata[31:0] onto the selected bytes.
  - In the write data phase, if no read address phase occurs in the same cycle, write the SRAM directly.
  - Otherwise load the buffer with row, mask and data.
- Buffer drain: in any cycle without an accepted read address phase, a valid buffer commits to the SRAM and is invalidated.
- Single-entry invariant: the buffer is always empty when a write data phase needs it.
  - Rationale: the preceding write address cycle was a drain cycle.
  - The implementation asserts this invariant in simulation.
- Forwarding: at a read address phase, if the row matches a valid buffer entry or a same-cycle write data phase, latch that mask and data. Read data is the SRAM output with forwarded bytes substituted.
- Write-to-write same row: the later write wins on overlapping bytes; non-overlapping bytes merge.
- Reserved hsize, or misalignment without SRAM_ADDR_CHK_EN: treated as word; offset is truncated to alignment.
- Idle, BUSY, or hsel=0: no SRAM access except a buffer drain.

Optional Feature:
- SRAM_ADDR_CHK_EN defined:
  - Conditions: an accepted transfer with haddr[31:BW+log2(DEPTH)] != BASE_ADDR's bits, reserved hsize, or misalignment (hword odd, word not 4-aligned, row not row-aligned).
  - Response: standard two-cycle AHB ERROR (cycle 1 hready=0 hresp=1; cycle 2 hready=1 hresp=1).
  - No SRAM access, no buffer change.
- Undefined: upper address bits are ignored (address wraps modulo window), hresp is tied 0, and hready is constantly 1.

Test Plan:
- Full-row write 0x0123..CDEF to row 5, idle, read row 5 -> hrdata equals written row one cycle after address phase; hready stays 1.
- Word write 0xDEADBEEF at byte 0x54 immediately followed by full-row read of row 5 -> bits 63:32 = DEADBEEF, other bytes unchanged; zero wait states.
- Write A, then three back-to-back reads of the same row, then idle -> all reads return A via the buffer; SRAM committed at the idle cycle; later read still returns A.
- Byte writes 0x11 at 0x0, then 0x22 at 0x1, then hword read at 0x0 -> hrdata = 0x0000_2211.
- With SRAM_ADDR_CHK_EN, read 0x3000_0000 -> hready 0 then 1 with hresp 1 on both cycles; word write at 0x2000_0002 -> error, memory unchanged.
- Assert hresetn mid-sequence with the buffer valid -> outputs return to reset values; no spurious SRAM write after release.
